mc_controller: RTL and testbench

//  Multicycle control FSM for the 8-bit MIPS datapath; sits directly upstream of the ALU.
//  - Decodes op/funct from the instruction register.
//  - Sequences fetch (4 byte-wide IR loads), decode, execute, memory and writeback.
//  - Drives every datapath mux/enable and the ALU's 3-bit alucontrol.
//  - Consumes the ALU zero flag to resolve beq.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_aludec.sv | 29 ++
 rtl/mc_controller.sv | 157 +++++++++++++++
 tb/tb_mc_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS controller, ALU and datapath.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH1  = 4'd0,
      S_FETCH2  = 4'd1,
      S_FETCH3  = 4'd2,
      S_FETCH4  = 4'd3,
      S_DECODE  = 4'd4,
      S_MEMADR  = 4'd5,
      S_LBRD    = 4'd6,
      S_LBWR    = 4'd7,
      S_SBWR    = 4'd8,
      S_RTYPEEX = 4'd9,
      S_RTYPEWR = 4'd10,
      S_BEQEX   = 4'd11,
      S_JEX     = 4'd12,
      S_ADDIEX  = 4'd13,
      S_ADDIWR  = 4'd14
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: aluop selects fixed add/sub or the R-type funct field.
module mc_aludec
   import mc_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alucontrol_o
);

   // Unknown aluop or funct falls back to add.
   always_comb begin
      alucontrol_o = ALU_ADD;
      case (aluop_i)
         ALUOP_SUB: alucontrol_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               FUNCT_ADD: alucontrol_o = ALU_ADD;
               FUNCT_SUB: alucontrol_o = ALU_SUB;
               FUNCT_AND: alucontrol_o = ALU_AND;
               FUNCT_OR:  alucontrol_o = ALU_OR;
               FUNCT_SLT: alucontrol_o = ALU_SLT;
               default:   alucontrol_o = ALU_ADD;
            endcase
         end
         default: alucontrol_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath.
//
// state     | meaning
// FETCH1-4  | load IR byte 0..3, PC += 1 each cycle
// DECODE    | compute branch target, dispatch on op
// MEMADR    | compute lb/sb effective address
// LBRD      | read memory at ALUOut
// LBWR      | write MDR to rt
// SBWR      | write memory at ALUOut
// RTYPEEX   | ALU op from funct
// RTYPEWR   | write ALUOut to rd
// BEQEX     | compare, PC <= branch target if zero
// JEX       | PC <= jump target
// ADDIEX    | regA + imm
// ADDIWR    | write ALUOut to rt
module mc_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       memread,
   output logic       memwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic [1:0] pcsource,
   output logic       pcen,
   output logic       iord,
   output logic [3:0] irwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg
);

   state_e     state_q;
   logic       pcwrite;
   logic       branch;
   logic [1:0] aluop;
   logic       memwrite_s;
   logic       regwrite_s;
   logic [3:0] irwrite_s;

   // State register with next-state decode; unused encodings recover to FETCH1.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH1;
      end else begin
         case (state_q)
            S_FETCH1: state_q <= S_FETCH2;
            S_FETCH2: state_q <= S_FETCH3;
            S_FETCH3: state_q <= S_FETCH4;
            S_FETCH4: state_q <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LB, OP_SB: state_q <= S_MEMADR;
                  OP_RTYPE:     state_q <= S_RTYPEEX;
                  OP_BEQ:       state_q <= S_BEQEX;
                  OP_J:         state_q <= S_JEX;
                  OP_ADDI:      state_q <= S_ADDIEX;
                  default:      state_q <= S_FETCH1;
               endcase
            end
            S_MEMADR: begin
               if (op == OP_SB)      state_q <= S_SBWR;
               else if (op == OP_LB) state_q <= S_LBRD;
               else                  state_q <= S_FETCH1;
            end
            S_LBRD:    state_q <= S_LBWR;
            S_RTYPEEX: state_q <= S_RTYPEWR;
            S_ADDIEX:  state_q <= S_ADDIWR;
            default:   state_q <= S_FETCH1;
         endcase
      end
   end

   // Moore output decode from the current state.
   always_comb begin
      memread    = 1'b0;
      memwrite_s = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_REGB;
      aluop      = ALUOP_ADD;
      pcsource   = PCSRC_ALU;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      irwrite_s  = 4'b0000;
      regwrite_s = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      case (state_q)
         S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
            memread   = 1'b1;
            alusrcb   = SRCB_ONE;
            pcwrite   = 1'b1;
            irwrite_s = 4'b0001 << state_q[1:0];
         end
         S_DECODE: alusrcb = SRCB_BOFF;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_LBRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_LBWR: begin
            regwrite_s = 1'b1;
            memtoreg   = 1'b1;
         end
         S_SBWR: begin
            memwrite_s = 1'b1;
            iord       = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWR: begin
            regwrite_s = 1'b1;
            regdst     = 1'b1;
         end
         S_BEQEX: begin
            alusrca  = 1'b1;
            aluop    = ALUOP_SUB;
            pcsource = PCSRC_ALUOUT;
            branch   = 1'b1;
         end
         S_JEX: begin
            pcwrite  = 1'b1;
            pcsource = PCSRC_JUMP;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_ADDIWR: regwrite_s = 1'b1;
         default: ;
      endcase
   end

   mc_aludec u_aludec (
      .aluop_i      (aluop),
      .funct_i      (funct),
      .alucontrol_o (alucontrol)
   );

   // Reset gates every committing enable so a mid-instruction reset writes nothing.
   assign memwrite = memwrite_s & ~reset;
   assign regwrite = regwrite_s & ~reset;
   assign irwrite  = reset ? 4'b0000 : irwrite_s;
   assign pcen     = ~reset & (pcwrite | (branch & zero));

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction table plus reset corner sequences.
module tb_mc_controller;

   typedef logic [18:0] vec_t;

   typedef struct {
      logic [5:0]      op;
      logic [5:0]      funct;
      logic            zero;
      int              ntail;
      logic [2:0][18:0] tail;
   } instr_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memread, memwrite, alusrca, pcen, iord, regwrite, regdst, memtoreg;
   logic [1:0] alusrcb, pcsource;
   logic [2:0] alucontrol;
   logic [3:0] irwrite;

   vec_t dut_vec;
   vec_t sb_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .memread    (memread),
      .memwrite   (memwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .alucontrol (alucontrol),
      .pcsource   (pcsource),
      .pcen       (pcen),
      .iord       (iord),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg)
   );

   always #5 clk = ~clk;

   assign dut_vec = {memread, memwrite, alusrca, alusrcb, alucontrol, pcsource,
                     pcen, iord, irwrite, regwrite, regdst, memtoreg};

   function automatic vec_t mk(input logic mr, input logic mw, input logic asa,
                               input logic [1:0] asb, input logic [2:0] ac,
                               input logic [1:0] ps, input logic pe, input logic io,
                               input logic [3:0] irw, input logic rw, input logic rd,
                               input logic mtr);
      return {mr, mw, asa, asb, ac, ps, pe, io, irw, rw, rd, mtr};
   endfunction

   function automatic instr_t mi(input logic [5:0] o, input logic [5:0] f, input logic z,
                                 input int n, input vec_t t0, input vec_t t1, input vec_t t2);
      instr_t r;
      r.op = o; r.funct = f; r.zero = z; r.ntail = n;
      r.tail[0] = t0; r.tail[1] = t1; r.tail[2] = t2;
      return r;
   endfunction

   // Scoreboard: compare each expected vector at the falling edge.
   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         vec_t e;
         e = sb_q.pop_front();
         n_total++;
         if (dut_vec !== e)
            $display("FAIL chk%0d outputs actual=%b required=%b", n_total, dut_vec, e);
         else
            n_pass++;
      end
   end

   // Drive one cycle of inputs and queue the outputs expected during it.
   task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic r, input vec_t e);
      op = o; funct = f; zero = z; reset = r;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   vec_t   fv[4];
   vec_t   dec, memadr, lbrd, lbwr, sbwr, rtwr, jex, addiex, addiwr, f1_rst, rtwr_rst, nil;
   instr_t prog[14];

   initial begin
      logic [3:0] one;
      instr_t p;
      one = 4'b0001;
      for (int k = 0; k < 4; k++)
         fv[k] = mk(1, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, one << k, 0, 0, 0);
      dec      = mk(0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0);
      memadr   = mk(0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0);
      lbrd     = mk(1, 0, 0, 2'b00, 3'b010, 2'b00, 0, 1, 4'b0000, 0, 0, 0);
      lbwr     = mk(0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 4'b0000, 1, 0, 1);
      sbwr     = mk(0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 1, 4'b0000, 0, 0, 0);
      rtwr     = mk(0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 4'b0000, 1, 1, 0);
      jex      = mk(0, 0, 0, 2'b00, 3'b010, 2'b10, 1, 0, 4'b0000, 0, 0, 0);
      addiex   = mk(0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0);
      addiwr   = mk(0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 4'b0000, 1, 0, 0);
      f1_rst   = mk(1, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0);
      rtwr_rst = mk(0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 1, 0);
      nil      = '0;

      prog[0]  = mi(6'b100000, 6'b000000, 1'b0, 3, memadr, lbrd, lbwr);
      prog[1]  = mi(6'b101000, 6'b000000, 1'b1, 2, memadr, sbwr, nil);
      prog[2]  = mi(6'b000000, 6'b101010, 1'b1, 2,
                    mk(0, 0, 1, 2'b00, 3'b111, 2'b00, 0, 0, 4'b0000, 0, 0, 0), rtwr, nil);
      prog[3]  = mi(6'b000000, 6'b100010, 1'b0, 2,
                    mk(0, 0, 1, 2'b00, 3'b110, 2'b00, 0, 0, 4'b0000, 0, 0, 0), rtwr, nil);
      prog[4]  = mi(6'b000000, 6'b100000, 1'b1, 2,
                    mk(0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0), rtwr, nil);
      prog[5]  = mi(6'b000000, 6'b100100, 1'b0, 2,
                    mk(0, 0, 1, 2'b00, 3'b000, 2'b00, 0, 0, 4'b0000, 0, 0, 0), rtwr, nil);
      prog[6]  = mi(6'b000000, 6'b100101, 1'b1, 2,
                    mk(0, 0, 1, 2'b00, 3'b001, 2'b00, 0, 0, 4'b0000, 0, 0, 0), rtwr, nil);
      prog[7]  = mi(6'b000000, 6'b000111, 1'b0, 2,
                    mk(0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0), rtwr, nil);
      prog[8]  = mi(6'b000100, 6'b101010, 1'b1, 1,
                    mk(0, 0, 1, 2'b00, 3'b110, 2'b01, 1, 0, 4'b0000, 0, 0, 0), nil, nil);
      prog[9]  = mi(6'b000100, 6'b100101, 1'b0, 1,
                    mk(0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 0, 4'b0000, 0, 0, 0), nil, nil);
      prog[10] = mi(6'b000010, 6'b000000, 1'b1, 1, jex, nil, nil);
      prog[11] = mi(6'b001000, 6'b100010, 1'b1, 2, addiex, addiwr, nil);
      prog[12] = mi(6'b111111, 6'b100010, 1'b1, 0, nil, nil, nil);
      prog[13] = mi(6'b000010, 6'b000000, 1'b0, 1, jex, nil, nil);

      reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
      @(posedge clk);
      #1;

      // Reset held: FETCH1 visible but no enables.
      for (int k = 0; k < 3; k++) step(6'b000000, 6'b000000, k[0], 1'b1, f1_rst);

      // Instruction program; zero is the opposite polarity outside execute states.
      for (int i = 0; i < 14; i++) begin
         p = prog[i];
         for (int k = 0; k < 4; k++) step(p.op, p.funct, ~p.zero, 1'b0, fv[k]);
         step(p.op, p.funct, ~p.zero, 1'b0, dec);
         for (int t = 0; t < p.ntail; t++) step(p.op, p.funct, p.zero, 1'b0, p.tail[t]);
      end

      // Reset arriving in RTYPEWR suppresses the regwrite, held 3 cycles.
      for (int k = 0; k < 4; k++) step(6'b000000, 6'b101010, 1'b0, 1'b0, fv[k]);
      step(6'b000000, 6'b101010, 1'b0, 1'b0, dec);
      step(6'b000000, 6'b101010, 1'b0, 1'b0,
           mk(0, 0, 1, 2'b00, 3'b111, 2'b00, 0, 0, 4'b0000, 0, 0, 0));
      step(6'b000000, 6'b101010, 1'b0, 1'b1, rtwr_rst);
      step(6'b000000, 6'b101010, 1'b0, 1'b1, f1_rst);
      step(6'b000000, 6'b101010, 1'b0, 1'b1, f1_rst);
      step(6'b000000, 6'b101010, 1'b0, 1'b0, fv[0]);
      step(6'b000000, 6'b101010, 1'b0, 1'b0, fv[1]);

      n_total++;
      if (sb_q.size() != 0)
         $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
      else
         n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
